cyber_player_multi: RTL

Parametrised multi-channel computer opponent for the LED game designs. Each channel runs its own maximal-length LFSR and compares a per-channel difficulty level against it every enabled cycle. A true compare produces a one-cycle press pulse, subject to a per-channel cooldown. Per-channel saturating press counters are provided. The block sits where switch/button inputs feed the game FSM and replaces single-channel, single-width opponents.

---
 rtl/cyber_player_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/cyber_player_multi.sv
// Multi-channel LFSR-driven computer opponent: per-channel press pulse, cooldown and saturating press counter.
// Latency: compare on the registered LFSR in cycle t is seen on press_o in cycle t+1.
// Backpressure: none; en_i low freezes every channel and holds press_o at 0.
//
// Ports:
//   clk_i      single clock, all state changes on its rising edge
//   reset_ni   asynchronous active-low reset, state held at reset values while low
//   en_i       advance enable for every channel
//   clear_i    synchronous clear of cooldowns, counters and press (LFSRs keep running)
//   level_i    per-channel difficulty, channel i at [i*(WIDTH-1) +: WIDTH-1]
//   press_o    registered one-cycle press pulse per channel
//   count_o    saturating press count, channel i at [i*CNT_W +: CNT_W]
module cyber_player_multi #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned COOLDOWN = 4,
    parameter int unsigned SEED     = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            en_i,
    input  logic                            clear_i,
    input  logic [CHANNELS*(WIDTH-1)-1:0]   level_i,
    output logic [CHANNELS-1:0]             press_o,
    output logic [CHANNELS*CNT_W-1:0]       count_o
);

    // Tap positions (1-based in the tap list) become bit masks on the LFSR.
    function automatic logic [11:0] taps_for(input int unsigned w);
        case (w)
            4:       taps_for = 12'h00C;   // 4,3
            5:       taps_for = 12'h014;   // 5,3
            6:       taps_for = 12'h030;   // 6,5
            7:       taps_for = 12'h060;   // 7,6
            8:       taps_for = 12'h0B8;   // 8,6,5,4
            9:       taps_for = 12'h110;   // 9,5
            10:      taps_for = 12'h240;   // 10,7
            11:      taps_for = 12'h500;   // 11,9
            12:      taps_for = 12'h829;   // 12,6,4,1
            default: taps_for = 12'h000;
        endcase
    endfunction

    localparam logic [11:0]       TAPS_ALL = taps_for(WIDTH);
    localparam logic [WIDTH-1:0]  TAP_MASK = TAPS_ALL[WIDTH-1:0];

    // A zero cooldown still needs a one-bit counter that simply stays at 0.
    localparam int unsigned       CD_W    = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [WIDTH-1:0] LFSR_SEED = WIDTH'(SEED + g);

        logic [WIDTH-1:0] lfsr_q, lfsr_d;
        logic [CD_W-1:0]  cd_q, cd_d;
        logic             press_q, press_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [WIDTH-2:0] lvl;
        logic             fire;

        assign lvl  = level_i[g*(WIDTH-1) +: (WIDTH-1)];
        // Zero-extended level against the registered LFSR; level 0 can never fire
        // because the LFSR is never 0.
        assign fire = ({1'b0, lvl} > lfsr_q);

        always_comb begin
            lfsr_d  = lfsr_q;
            cd_d    = cd_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            if (en_i) begin
                // The LFSR advances on every enabled edge, clear or not.
                lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAP_MASK)};
                if (clear_i) begin
                    cd_d  = '0;
                    cnt_d = '0;
                end else if ((cd_q == '0) && fire) begin
                    press_d = 1'b1;
                    cd_d    = CD_LOAD;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cd_q != '0) begin
                    cd_d = cd_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                lfsr_q  <= LFSR_SEED;
                cd_q    <= '0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                lfsr_q  <= lfsr_d;
                cd_q    <= cd_d;
                press_q <= press_d;
                cnt_q   <= cnt_d;
            end
        end

        assign press_o[g]                 = press_q;
        assign count_o[g*CNT_W +: CNT_W]  = cnt_q;
    end

endmodule
